// File: rtl/crc_seq_pkg.sv
// crc_seq_pkg: shared FSM states, write-size encodings and size decode for the CRC byte sequencer
package crc_seq_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_FINAL, S_SETTLE} state_t;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    return sz == SZ_B ? 3'd1 : sz == SZ_H ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/crc_word_fifo.sv
// crc_word_fifo: DEPTH-entry word FIFO holding {size, data} with flush and occupancy level
module crc_word_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 34
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [W-1:0]             i_wdata,
  input  logic                     i_pop,
  output logic [W-1:0]             o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic w_push, w_pop;
  assign o_full = r_cnt == (AW+1)'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign o_level = r_cnt;
  assign o_rdata = r_mem[r_rp];
  assign w_push = i_push && !o_full;
  assign w_pop = i_pop && !o_empty;
  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wp] <= i_wdata;
  end
  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= w_push && !w_pop ? r_cnt + 1'b1 : w_pop && !w_push ? r_cnt - 1'b1 : r_cnt;
    end
  end
endmodule

// File: rtl/crc_byte_sequencer.sv
// crc_byte_sequencer: queues bus writes and feeds them byte-serially into the CRC32 engine
module crc_byte_sequencer
  import crc_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int RES_LAT = 2,
  parameter int TIMEOUT = 15,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_wr_valid,
  input  logic [31:0]              i_wr_data,
  input  logic [1:0]               i_wr_size,
  output logic                     o_wr_ready,
  input  logic                     i_finalize,
  input  logic                     i_abort,
  output logic                     o_crc_trigger,
  output logic [7:0]               o_crc_byte,
  input  logic                     i_crc_busy,
  input  logic                     i_crc_done,
  output logic                     o_crc_data_done,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic [CNT_W-1:0]         o_byte_count,
  output logic                     o_busy,
  output logic                     o_result_valid,
  output logic                     o_error,
  output logic                     o_irq,
  input  logic                     i_irq_clr
);
  localparam int CW = $clog2(TIMEOUT + RES_LAT + 1) + 1;
  state_t r_state;
  logic [31:0] r_shift;
  logic [2:0] r_left;
  logic [CW-1:0] r_cnt;
  logic r_fin_pend, r_trig, r_dd, r_rv, r_err, r_irq;
  logic [7:0] r_byte;
  logic [CNT_W-1:0] r_bcnt;
  logic w_acc, w_ill, w_push, w_pop, w_full, w_empty, w_timeout, w_settled, w_flush;
  logic [33:0] w_rdata;
  assign o_wr_ready = !w_full && !r_fin_pend && r_state != S_FINAL && r_state != S_SETTLE;
  assign w_acc = i_wr_valid && o_wr_ready && !i_abort;
  assign w_ill = w_acc && i_wr_size == 2'b11;
  assign w_push = w_acc && !w_ill;
  assign w_pop = !i_abort && r_state == S_IDLE && !w_empty;
  assign w_timeout = !i_abort && r_state == S_WAIT && !i_crc_done && r_cnt == CW'(TIMEOUT - 1);
  assign w_settled = !i_abort && r_state == S_SETTLE && r_cnt >= CW'(RES_LAT - 1);
  assign w_flush = i_abort || w_timeout;
  assign o_busy = r_state != S_IDLE || !w_empty || r_fin_pend;
  assign o_crc_trigger = r_trig;
  assign o_crc_byte = r_byte;
  assign o_crc_data_done = r_dd;
  assign o_byte_count = r_bcnt;
  assign o_result_valid = r_rv;
  assign o_error = r_err;
  assign o_irq = r_irq;
  crc_word_fifo #(.DEPTH(DEPTH), .W(34)) u_fifo (
    .clk(clk), .rst_n(rst_n), .i_flush(w_flush), .i_push(w_push),
    .i_wdata({i_wr_size, i_wr_data}), .i_pop(w_pop), .o_rdata(w_rdata),
    .o_full(w_full), .o_empty(w_empty), .o_level(o_level)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_left <= '0;
      r_cnt <= '0;
      r_fin_pend <= 1'b0;
      r_trig <= 1'b0;
      r_byte <= '0;
      r_dd <= 1'b0;
      r_bcnt <= '0;
      r_rv <= 1'b0;
      r_err <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      r_trig <= 1'b0;
      r_dd <= 1'b0;
      // a new error or completion in the same cycle as irq_clr takes precedence
      r_err <= (w_ill || w_timeout) ? 1'b1 : i_irq_clr ? 1'b0 : r_err;
      r_irq <= (w_ill || w_timeout || w_settled) ? 1'b1 : i_irq_clr ? 1'b0 : r_irq;
      if (i_abort) begin
        r_state <= S_IDLE;
        r_fin_pend <= 1'b0;
        r_bcnt <= '0;
        r_rv <= 1'b0;
      end else begin
        if (w_acc) r_rv <= 1'b0;
        if (i_finalize) r_fin_pend <= 1'b1;
        case (r_state)
          S_IDLE: begin
            if (!w_empty) begin
              r_shift <= w_rdata[31:0];
              r_left <= size_bytes(w_rdata[33:32]);
              r_state <= S_LOAD;
            end else if (r_fin_pend) begin
              r_dd <= 1'b1;
              r_fin_pend <= 1'b0;
              r_state <= S_FINAL;
            end
          end
          S_LOAD: begin
            if (!i_crc_busy) begin
              r_trig <= 1'b1;
              r_byte <= r_shift[7:0];
              r_state <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            r_cnt <= '0;
            r_state <= S_WAIT;
          end
          S_WAIT: begin
            if (i_crc_done) begin
              r_shift <= r_shift >> 8;
              r_left <= r_left - 3'd1;
              r_bcnt <= r_bcnt + 1'b1;
              r_state <= r_left == 3'd1 ? S_IDLE : S_ISSUE;
              r_trig <= r_left != 3'd1;
              r_byte <= r_shift[15:8];
            end else if (w_timeout) begin
              r_fin_pend <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_FINAL: begin
            // the FINAL cycle counts toward the result latency
            r_cnt <= CW'(1);
            r_state <= S_SETTLE;
          end
          S_SETTLE: begin
            if (w_settled) begin
              r_rv <= 1'b1;
              r_bcnt <= '0;
              r_state <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_crc_byte_sequencer.sv
// tb_crc_byte_sequencer: directed steps with an engine model and a byte scoreboard
module tb_crc_byte_sequencer;
  import crc_seq_pkg::*;
  logic clk = 0, rst_n = 0, wr_valid = 0, finalize = 0, abort = 0, crc_busy = 0, crc_done = 0, irq_clr = 0;
  logic [31:0] wr_data = 0;
  logic [1:0] wr_size = 0;
  logic wr_ready, crc_trigger, crc_data_done, busy, result_valid, error, irq;
  logic [7:0] crc_byte;
  logic [2:0] level;
  logic [15:0] byte_count;
  int checks = 0, failures = 0, cyc = 0, trig_cnt = 0, dd_cnt = 0, dd_cyc = 0, last_trig_cyc = 0, cd = 0;
  int t_snap, d_snap;
  bit done_en = 1;
  logic prev_rv = 0;
  logic [7:0] exp_q[$];

  crc_byte_sequencer dut (
    .clk(clk), .rst_n(rst_n), .i_wr_valid(wr_valid), .i_wr_data(wr_data), .i_wr_size(wr_size),
    .o_wr_ready(wr_ready), .i_finalize(finalize), .i_abort(abort), .o_crc_trigger(crc_trigger),
    .o_crc_byte(crc_byte), .i_crc_busy(crc_busy), .i_crc_done(crc_done), .o_crc_data_done(crc_data_done),
    .o_level(level), .o_byte_count(byte_count), .o_busy(busy), .o_result_valid(result_valid),
    .o_error(error), .o_irq(irq), .i_irq_clr(irq_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // engine model (done 2 cycles after trigger) plus output scoreboard
  always @(negedge clk) begin
    crc_done = 0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) crc_done = 1;
    end
    if (crc_trigger) begin
      trig_cnt++;
      last_trig_cyc = cyc;
      if (done_en) cd = 2;
      chk("trigger_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("crc_byte", 32'(crc_byte), 32'(exp_q.pop_front()));
    end
    if (crc_data_done) begin
      dd_cnt++;
      dd_cyc = cyc;
      chk("dd_after_last_byte", 32'(exp_q.size()), 0);
    end
    if (result_valid && !prev_rv) begin
      chk("rv_latency", 32'(cyc - dd_cyc), 2);
      chk("rv_irq", 32'(irq), 1);
    end
    prev_rv = result_valid;
  end

  task automatic wr_drive(input logic [31:0] d, input logic [1:0] s);
    @(negedge clk);
    wr_valid = 1;
    wr_data = d;
    wr_size = s;
  endtask

  task automatic wr_finish();
    int nb;
    for (int n = 0; n < 200 && !wr_ready; n++) @(negedge clk);
    chk("wr_accept", 32'(wr_ready), 1);
    nb = wr_size == 2'b00 ? 1 : wr_size == 2'b01 ? 2 : wr_size == 2'b10 ? 4 : 0;
    for (int i = 0; i < nb; i++) exp_q.push_back(wr_data[8*i +: 8]);
    @(negedge clk);
    wr_valid = 0;
  endtask

  task automatic wr(input logic [31:0] d, input logic [1:0] s);
    wr_drive(d, s);
    wr_finish();
  endtask

  task automatic pulse_fin();
    @(negedge clk);
    finalize = 1;
    @(negedge clk);
    finalize = 0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    irq_clr = 1;
    @(negedge clk);
    irq_clr = 0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 500 && busy; n++) @(negedge clk);
    chk("idle_reached", 32'(busy), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_wr_ready", 32'(wr_ready), 1);
    chk("rst_level", 32'(level), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_trigger", 32'(crc_trigger), 0);
    chk("rst_error_irq", {error, irq, result_valid, crc_data_done}, 0);
    chk("rst_byte_count", 32'(byte_count), 0);
    rst_n = 1;
    // single word, with first-trigger latency
    wr(32'h04030201, SZ_W);
    chk("lat_c0", 32'(crc_trigger), 0);
    @(negedge clk);
    chk("lat_c1", 32'(crc_trigger), 0);
    @(negedge clk);
    chk("lat_c2", 32'(crc_trigger), 1);
    wait_idle();
    chk("single_bc", 32'(byte_count), 4);
    chk("single_trigs", 32'(trig_cnt), 4);
    chk("single_q", 32'(exp_q.size()), 0);
    // mixed sizes plus finalize
    wr(32'h000000AA, SZ_B);
    wr(32'h0000CCBB, SZ_H);
    pulse_fin();
    wait_idle();
    chk("mixed_q", 32'(exp_q.size()), 0);
    chk("mixed_dd", 32'(dd_cnt), 1);
    chk("mixed_rv", 32'(result_valid), 1);
    chk("mixed_irq", 32'(irq), 1);
    chk("mixed_bc", 32'(byte_count), 0);
    pulse_clr();
    chk("mixed_irq_clr", 32'(irq), 0);
    // backpressure with the engine stalled
    crc_busy = 1;
    for (int i = 0; i < 5; i++) wr(32'h11223344 + 32'(i) * 32'h01010101, SZ_W);
    chk("bp_rv_cleared", 32'(result_valid), 0);
    chk("bp_level", 32'(level), 4);
    chk("bp_ready", 32'(wr_ready), 0);
    wr_drive(32'hA5A55A5A, SZ_W);
    repeat (5) @(negedge clk);
    chk("bp_hold_ready", 32'(wr_ready), 0);
    chk("bp_hold_level", 32'(level), 4);
    crc_busy = 0;
    wr_finish();
    wait_idle();
    chk("bp_q", 32'(exp_q.size()), 0);
    chk("bp_bc", 32'(byte_count), 24);
    // watchdog
    done_en = 0;
    wr(32'h00000011, SZ_B);
    wr(32'h00000022, SZ_B);
    for (int n = 0; n < 60 && !error; n++) @(negedge clk);
    chk("wd_error", 32'(error), 1);
    chk("wd_latency", 32'(cyc - last_trig_cyc), 16);
    chk("wd_irq", 32'(irq), 1);
    chk("wd_level", 32'(level), 0);
    chk("wd_busy", 32'(busy), 0);
    exp_q.delete();
    done_en = 1;
    pulse_clr();
    chk("wd_clr", {error, irq}, 0);
    // abort in WAIT of byte 2 with a same-cycle write and finalize
    wr(32'hDDCCBBAA, SZ_W);
    for (int n = 0; n < 50 && !(crc_trigger && crc_byte == 8'hBB); n++) @(negedge clk);
    chk("ab_reached_b2", 32'(crc_byte), 32'hBB);
    @(negedge clk);
    abort = 1;
    wr_valid = 1;
    wr_data = 32'h00000099;
    wr_size = SZ_B;
    finalize = 1;
    exp_q.delete();
    t_snap = trig_cnt;
    d_snap = dd_cnt;
    @(negedge clk);
    abort = 0;
    wr_valid = 0;
    finalize = 0;
    chk("ab_trigger", 32'(crc_trigger), 0);
    chk("ab_level", 32'(level), 0);
    chk("ab_bc", 32'(byte_count), 0);
    repeat (10) @(negedge clk);
    chk("ab_no_trig", 32'(trig_cnt), 32'(t_snap));
    chk("ab_no_dd", 32'(dd_cnt), 32'(d_snap));
    chk("ab_busy", 32'(busy), 0);
    chk("ab_level_late", 32'(level), 0);
    // illegal size with a non-empty FIFO
    crc_busy = 1;
    wr(32'h00000077, SZ_B);
    wr(32'h00000088, SZ_B);
    chk("ill_level_pre", 32'(level), 1);
    wr(32'h00001234, 2'b11);
    chk("ill_error", 32'(error), 1);
    chk("ill_irq", 32'(irq), 1);
    chk("ill_level", 32'(level), 1);
    crc_busy = 0;
    wait_idle();
    chk("ill_bc", 32'(byte_count), 2);
    pulse_clr();
    chk("ill_clr", {error, irq}, 0);
    // empty-message finalize
    d_snap = dd_cnt;
    pulse_fin();
    wait_idle();
    chk("emp_dd", 32'(dd_cnt), 32'(d_snap + 1));
    chk("emp_rv", 32'(result_valid), 1);
    chk("emp_bc", 32'(byte_count), 0);
    chk("end_q", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
